// File: rtl/text_console.sv
// Character-cell text console: converts a byte stream into character-RAM writes,
// tracking the cursor and handling wrap, line clear and full-screen clear.
module text_console #(
   parameter int COLS = 80,
   parameter int ROWS = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_ascii,
   input  logic [11:0] in_fg,
   input  logic [11:0] in_bg,
   output logic        mem_we,
   output logic [12:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [6:0]  cur_x,
   output logic [5:0]  cur_y,
   output logic        busy
);

   localparam logic [6:0]  X_LAST = 7'(COLS - 1);
   localparam logic [5:0]  Y_LAST = 6'(ROWS - 1);
   localparam logic [31:0] BLANK  = 32'hFFF0_0020;
   localparam logic [7:0]  CH_BS  = 8'h08;
   localparam logic [7:0]  CH_LF  = 8'h0A;
   localparam logic [7:0]  CH_FF  = 8'h0C;
   localparam logic [7:0]  CH_CR  = 8'h0D;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLEAR_LINE,
      CLEAR_ALL
   } state_e;

   state_e      state_q, state_d;
   logic [6:0]  cur_x_q, cur_x_d;
   logic [5:0]  cur_y_q, cur_y_d;
   logic [6:0]  clr_x_q, clr_x_d;
   logic [5:0]  clr_y_q, clr_y_d;
   logic        nl_pending_q, nl_pending_d;
   logic        mem_we_q, mem_we_d;
   logic [12:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        in_ready_q, in_ready_d;
   logic        busy_q, busy_d;

   logic        accept;
   logic        printable;
   logic [5:0]  y_next;

   assign accept    = in_valid && in_ready_q;
   assign printable = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
   assign y_next    = (cur_y_q == Y_LAST) ? '0 : cur_y_q + 6'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CLEAR_ALL;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         clr_x_q      <= '0;
         clr_y_q      <= '0;
         nl_pending_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         clr_x_q      <= clr_x_d;
         clr_y_q      <= clr_y_d;
         nl_pending_q <= nl_pending_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
      end
   end

   // clr_x/clr_y always name the cell whose write is on the outputs this cycle
   always_comb begin
      state_d      = state_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      clr_x_d      = clr_x_q;
      clr_y_d      = clr_y_q;
      nl_pending_d = nl_pending_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = WRITE;
               nl_pending_d = 1'b0;
               if (printable) begin
                  if (cur_x_q == X_LAST) begin
                     cur_x_d      = '0;
                     cur_y_d      = y_next;
                     nl_pending_d = 1'b1;
                  end else begin
                     cur_x_d = cur_x_q + 7'd1;
                  end
               end else begin
                  case (in_ascii)
                     CH_LF: begin
                        cur_x_d = '0;
                        cur_y_d = y_next;
                        clr_x_d = '0;
                        clr_y_d = y_next;
                        state_d = CLEAR_LINE;
                     end
                     CH_CR: cur_x_d = '0;
                     CH_BS: begin
                        if (cur_x_q != '0) cur_x_d = cur_x_q - 7'd1;
                     end
                     CH_FF: begin
                        cur_x_d = '0;
                        cur_y_d = '0;
                        clr_x_d = '0;
                        clr_y_d = '0;
                        state_d = CLEAR_ALL;
                     end
                     default: ;
                  endcase
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
            if (nl_pending_q) begin
               state_d      = CLEAR_LINE;
               clr_x_d      = '0;
               clr_y_d      = cur_y_q;
               nl_pending_d = 1'b0;
            end
         end
         CLEAR_LINE: begin
            if (clr_x_q == X_LAST) state_d = IDLE;
            else                   clr_x_d = clr_x_q + 7'd1;
         end
         CLEAR_ALL: begin
            // mem_we low here only right after reset: cell (0,0) is not yet written
            if (mem_we_q) begin
               if (clr_x_q == X_LAST) begin
                  clr_x_d = '0;
                  if (clr_y_q == Y_LAST) state_d = IDLE;
                  else                   clr_y_d = clr_y_q + 6'd1;
               end else begin
                  clr_x_d = clr_x_q + 7'd1;
               end
            end
         end
         default: state_d = CLEAR_ALL;
      endcase
   end

   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      if ((state_d == CLEAR_LINE) || (state_d == CLEAR_ALL)) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = {clr_x_d, clr_y_d};
         mem_wdata_d = BLANK;
      end else if (accept && printable) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = {cur_x_q, cur_y_q};
         mem_wdata_d = {in_fg, in_bg, in_ascii};
      end else if (accept && (in_ascii == CH_BS) && (cur_x_q != '0)) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = {cur_x_q - 7'd1, cur_y_q};
         mem_wdata_d = BLANK;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cur_x     = cur_x_q;
   assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: vector table for single bytes plus
// sequences for wrap, clears, backspace and reset abort.
module tb_text_console;

   localparam int          COLS  = 80;
   localparam int          ROWS  = 60;
   localparam logic [31:0] BLANK = 32'hFFF0_0020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_ascii = '0;
   logic [11:0] in_fg = '0;
   logic [11:0] in_bg = '0;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [6:0]  cur_x;
   logic [5:0]  cur_y;
   logic        busy;

   text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ascii(in_ascii),
      .in_fg(in_fg), .in_bg(in_bg),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   logic [12:0] mon_addr[$];
   logic [31:0] mon_data[$];
   int unsigned mon_cyc[$];

   always @(negedge clk) begin
      if (!rst && mem_we) begin
         mon_addr.push_back(mem_addr);
         mon_data.push_back(mem_wdata);
         mon_cyc.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: got timeout, expected summary before 60000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon_clear();
      mon_addr.delete();
      mon_data.delete();
      mon_cyc.delete();
   endtask

   task automatic send(input logic [7:0] a, input logic [11:0] fg, input logic [11:0] bg,
                       output int busy_n);
      int n;
      n = 0;
      while (!in_ready && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_wait: got in_ready=0, expected 1 within 10000 cycles");
      end
      mon_clear();
      in_ascii = a;
      in_fg    = fg;
      in_bg    = bg;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      busy_n = 0;
      @(negedge clk);
      while (!in_ready && busy_n < 10000) begin
         busy_n++;
         @(negedge clk);
      end
   endtask

   task automatic send_n(input logic [7:0] a, input int count);
      int bn;
      for (int i = 0; i < count; i++) send(a, 12'h0F0, 12'h000, bn);
   endtask

   task automatic check_clear(input string pfx, input int skip, input int n_exp, input int row);
      int          order_err;
      int          blank_err;
      logic [12:0] e;
      order_err = 0;
      blank_err = 0;
      chk({pfx, "_count"}, 32'(mon_addr.size()), 32'(skip + n_exp));
      for (int i = 0; i < n_exp && skip + i < mon_addr.size(); i++) begin
         e = {7'(i % COLS), 6'(row + i / COLS)};
         if (mon_addr[skip + i] !== e) order_err++;
         if (mon_data[skip + i] !== BLANK) blank_err++;
      end
      chk({pfx, "_order_errs"}, 32'(order_err), 32'd0);
      chk({pfx, "_blank_errs"}, 32'(blank_err), 32'd0);
      if (mon_addr.size() > 0)
         chk({pfx, "_consecutive"}, mon_cyc[$] - mon_cyc[0], 32'(mon_addr.size() - 1));
   endtask

   task automatic check_reset_state(input string pfx);
      chk({pfx, "_in_ready"},  32'(in_ready),  32'd0);
      chk({pfx, "_busy"},      32'(busy),      32'd1);
      chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
      chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
      chk({pfx, "_mem_wdata"}, mem_wdata,      32'd0);
      chk({pfx, "_cur_x"},     32'(cur_x),     32'd0);
      chk({pfx, "_cur_y"},     32'(cur_y),     32'd0);
   endtask

   task automatic release_and_check(input string pfx);
      int unsigned rel;
      int          n;
      @(negedge clk);
      mon_clear();
      rst = 1'b0;
      rel = cyc;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 6000) begin
         n++;
         @(negedge clk);
      end
      chk({pfx, "_ready_rise"}, 32'(in_ready), 32'd1);
      check_clear(pfx, 0, COLS * ROWS, 0);
      if (mon_addr.size() > 0) begin
         chk({pfx, "_first_edge"}, mon_cyc[0], rel + 1);
         chk({pfx, "_ready_after_last"}, cyc, mon_cyc[$] + 1);
      end
      chk({pfx, "_cur_x"}, 32'(cur_x), 32'd0);
      chk({pfx, "_cur_y"}, 32'(cur_y), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [11:0] fg;
      logic [11:0] bg;
      int          n_wr;
      logic [12:0] a_first;
      logic [12:0] a_last;
      logic [31:0] d;
      logic [6:0]  x;
      logic [5:0]  y;
      int          busy_n;
   } vec_t;

   localparam int NV = 16;
   vec_t v[NV];

   initial begin
      int    bn;
      int    n;
      bit    found;
      string p;

      v[0]  = '{8'h41, 12'hF00, 12'h000, 1,    13'h0000, 13'h0000, 32'hF000_0041, 7'd1, 6'd0, 1};
      v[1]  = '{8'h7A, 12'h0F0, 12'h00F, 1,    13'h0040, 13'h0040, 32'h0F00_0F7A, 7'd2, 6'd0, 1};
      v[2]  = '{8'h0D, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[3]  = '{8'h7E, 12'h123, 12'h456, 1,    13'h0000, 13'h0000, 32'h1234_567E, 7'd1, 6'd0, 1};
      v[4]  = '{8'h08, 12'h000, 12'h000, 1,    13'h0000, 13'h0000, BLANK,         7'd0, 6'd0, 1};
      v[5]  = '{8'h08, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[6]  = '{8'h7F, 12'hFFF, 12'hFFF, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[7]  = '{8'h00, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[8]  = '{8'h1B, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[9]  = '{8'h09, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd0, 1};
      v[10] = '{8'h20, 12'hAAA, 12'h555, 1,    13'h0000, 13'h0000, 32'hAAA5_5520, 7'd1, 6'd0, 1};
      v[11] = '{8'h0A, 12'h000, 12'h000, 80,   13'h0001, 13'h13C1, BLANK,         7'd0, 6'd1, 80};
      v[12] = '{8'h80, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd1, 1};
      v[13] = '{8'hFF, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd1, 1};
      v[14] = '{8'h1F, 12'h000, 12'h000, 0,    13'h0000, 13'h0000, 32'h0,         7'd0, 6'd1, 1};
      v[15] = '{8'h0C, 12'h000, 12'h000, 4800, 13'h0000, 13'h13FB, BLANK,         7'd0, 6'd0, 4800};

      repeat (3) @(negedge clk);
      check_reset_state("rst");
      release_and_check("init");

      for (int i = 0; i < NV; i++) begin
         p = $sformatf("v%0d", i);
         send(v[i].a, v[i].fg, v[i].bg, bn);
         chk({p, "_nwr"}, 32'(mon_addr.size()), 32'(v[i].n_wr));
         if (v[i].n_wr > 0 && mon_addr.size() > 0) begin
            chk({p, "_addr_first"}, 32'(mon_addr[0]), 32'(v[i].a_first));
            chk({p, "_addr_last"},  32'(mon_addr[$]), 32'(v[i].a_last));
            chk({p, "_data_first"}, mon_data[0], v[i].d);
            chk({p, "_data_last"},  mon_data[$], v[i].d);
         end
         chk({p, "_cur_x"}, 32'(cur_x), 32'(v[i].x));
         chk({p, "_cur_y"}, 32'(cur_y), 32'(v[i].y));
         chk({p, "_busy_cycles"}, 32'(bn), 32'(v[i].busy_n));
      end

      // Row 0 wrap: 80th char lands at column 79, then row 1 is blanked
      send_n(8'h42, 79);
      chk("wrap_pre_x", 32'(cur_x), 32'd79);
      chk("wrap_pre_y", 32'(cur_y), 32'd0);
      send(8'h42, 12'h00F, 12'hF00, bn);
      if (mon_addr.size() > 0) begin
         chk("wrap_char_addr", 32'(mon_addr[0]), 32'h13C0);
         chk("wrap_char_data", mon_data[0], 32'h00FF_0042);
      end
      check_clear("wrap", 1, 80, 1);
      chk("wrap_cur_x", 32'(cur_x), 32'd0);
      chk("wrap_cur_y", 32'(cur_y), 32'd1);
      chk("wrap_busy_cycles", 32'(bn), 32'd81);

      // Newline on the last row wraps to row 0
      send_n(8'h0A, 58);
      send_n(8'h78, 5);
      chk("lf59_pre_x", 32'(cur_x), 32'd5);
      chk("lf59_pre_y", 32'(cur_y), 32'd59);
      send(8'h0A, 12'h000, 12'h000, bn);
      check_clear("lf59", 0, 80, 0);
      chk("lf59_cur_x", 32'(cur_x), 32'd0);
      chk("lf59_cur_y", 32'(cur_y), 32'd0);

      // Backspace at (3,7), then at column 0
      send_n(8'h0A, 7);
      send_n(8'h63, 3);
      send(8'h08, 12'h000, 12'h000, bn);
      chk("bs_nwr", 32'(mon_addr.size()), 32'd1);
      if (mon_addr.size() > 0) begin
         chk("bs_addr", 32'(mon_addr[0]), 32'h0087);
         chk("bs_data", mon_data[0], BLANK);
      end
      chk("bs_cur_x", 32'(cur_x), 32'd2);
      chk("bs_cur_y", 32'(cur_y), 32'd7);
      send(8'h0D, 12'h000, 12'h000, bn);
      send(8'h08, 12'h000, 12'h000, bn);
      chk("bs0_nwr", 32'(mon_addr.size()), 32'd0);
      chk("bs0_cur_x", 32'(cur_x), 32'd0);
      chk("bs0_cur_y", 32'(cur_y), 32'd7);

      // Form feed, then fill to the final cell and write it
      send(8'h0C, 12'h000, 12'h000, bn);
      check_clear("ff", 0, COLS * ROWS, 0);
      send_n(8'h0A, 59);
      send_n(8'h65, 79);
      chk("last_pre_x", 32'(cur_x), 32'd79);
      chk("last_pre_y", 32'(cur_y), 32'd59);
      send(8'h65, 12'h000, 12'h000, bn);
      if (mon_addr.size() > 0) chk("last_char_addr", 32'(mon_addr[0]), 32'h13FB);
      check_clear("last", 1, 80, 0);
      chk("last_cur_x", 32'(cur_x), 32'd0);
      chk("last_cur_y", 32'(cur_y), 32'd0);

      // Reset asserted in the middle of a line clear
      n = 0;
      while (!in_ready && n < 10000) begin
         @(negedge clk);
         n++;
      end
      in_ascii = 8'h0A;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (mem_we && mem_addr[12:6] == 7'd40) found = 1'b1;
      end
      chk("abort_reached_x40", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_state("abort");
      repeat (3) @(negedge clk);
      release_and_check("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
